// File: rtl/barrel_shift_arbiter.sv
// Round-robin shares one 8-bit rotator between two valid/ready requesters; result registered (1-cycle latency).
// A held result that is not drained blocks all grants; drain and load may happen on the same edge.
module barrel_shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [7:0]       r0_data,
    input  logic [2:0]       r0_amt,
    input  logic             r0_dir,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [7:0]       r1_data,
    input  logic [2:0]       r1_amt,
    input  logic             r1_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             prio_q,      prio_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             out_id_q,    out_id_d;
    logic [CNT_W-1:0] cnt0_q,      cnt0_d;
    logic [CNT_W-1:0] cnt1_q,      cnt1_d;
    logic             can_load;
    logic             gnt0;
    logic             gnt1;

    // Doubling the operand turns a cyclic rotate into a plain shift plus slice.
    function automatic logic [7:0] rotate8(input logic [7:0] d, input logic [2:0] k,
                                           input logic left);
        logic [15:0] w;
        if (left) begin
            w = {d, d} << k;
            rotate8 = w[15:8];
        end else begin
            w = {d, d} >> k;
            rotate8 = w[7:0];
        end
    endfunction

    always_comb begin
        can_load    = !out_valid_q || out_ready;
        gnt0        = rst_n && can_load && r0_valid && (!r1_valid || !prio_q);
        gnt1        = rst_n && can_load && r1_valid && (!r0_valid ||  prio_q);

        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;

        if (gnt0) begin
            out_data_d  = rotate8(r0_data, r0_amt, r0_dir);
            out_id_d    = 1'b0;
            out_valid_d = 1'b1;
            prio_d      = 1'b1;
            if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
        end else if (gnt1) begin
            out_data_d  = rotate8(r1_data, r1_amt, r1_dir);
            out_id_d    = 1'b1;
            out_valid_d = 1'b1;
            prio_d      = 1'b0;
            if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_id_q    <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign r0_ready  = gnt0;
    assign r1_ready  = gnt1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: a 16-bit and a 2-bit counter instance share stimulus and are
// compared every cycle against a job-level model, plus directed literal checks.
module tb_barrel_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r0_dir, r1_valid, r1_dir, out_ready;
    logic [7:0] r0_data, r1_data;
    logic [2:0] r0_amt, r1_amt;

    logic        r0_ready, r1_ready, out_valid, out_id;
    logic [7:0]  out_data;
    logic [15:0] cnt0, cnt1;
    logic        s_r0_ready, s_r1_ready, s_out_valid, s_out_id;
    logic [7:0]  s_out_data;
    logic [1:0]  s_cnt0, s_cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    barrel_shift_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_amt(r0_amt), .r0_dir(r0_dir),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_amt(r1_amt), .r1_dir(r1_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    barrel_shift_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(s_r0_ready), .r0_data(r0_data), .r0_amt(r0_amt), .r0_dir(r0_dir),
        .r1_valid(r1_valid), .r1_ready(s_r1_ready), .r1_data(r1_data), .r1_amt(r1_amt), .r1_dir(r1_dir),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_id(s_out_id),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit-by-bit rotation straight from the index formulas.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int k, input logic left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (left) r[i] = d[(i - k + 8) % 8];
            else      r[i] = d[(i + k) % 8];
        end
        return r;
    endfunction

    // Job-level model state; counts are unbounded and clipped per instance width.
    bit         m_init = 0;
    bit         m_vld;
    logic [7:0] m_data;
    bit         m_id;
    bit         m_prio;
    int         m_c0, m_c1;

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(negedge clk) begin
        bit can, e0, e1;
        can = !m_vld || out_ready;
        e0  = rst_n && m_init && can && r0_valid && (!r1_valid || !m_prio);
        e1  = rst_n && m_init && can && r1_valid && (!r0_valid ||  m_prio);
        if (m_init || !rst_n) begin
            chk("r0_ready", {31'b0, r0_ready}, {31'b0, e0});
            chk("r1_ready", {31'b0, r1_ready}, {31'b0, e1});
            chk("s_r0_ready", {31'b0, s_r0_ready}, {31'b0, e0});
            chk("s_r1_ready", {31'b0, s_r1_ready}, {31'b0, e1});
        end
        if (m_init) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
            chk("out_data", {24'b0, out_data}, {24'b0, m_data});
            chk("out_id", {31'b0, out_id}, {31'b0, m_id});
            chk("cnt0", {16'b0, cnt0}, clip(m_c0, 65535));
            chk("cnt1", {16'b0, cnt1}, clip(m_c1, 65535));
            chk("s_out_valid", {31'b0, s_out_valid}, {31'b0, m_vld});
            chk("s_out_data", {24'b0, s_out_data}, {24'b0, m_data});
            chk("s_out_id", {31'b0, s_out_id}, {31'b0, m_id});
            chk("s_cnt0", {30'b0, s_cnt0}, clip(m_c0, 3));
            chk("s_cnt1", {30'b0, s_cnt1}, clip(m_c1, 3));
        end
        if (!rst_n) begin
            m_init = 1; m_vld = 0; m_data = 8'h00; m_id = 0; m_prio = 0; m_c0 = 0; m_c1 = 0;
        end else if (m_init) begin
            if (e0) begin
                m_vld = 1; m_data = ref_rot(r0_data, int'(r0_amt), r0_dir); m_id = 0;
                m_prio = 1; m_c0++;
            end else if (e1) begin
                m_vld = 1; m_data = ref_rot(r1_data, int'(r1_amt), r1_dir); m_id = 1;
                m_prio = 0; m_c1++;
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic job1(input logic [7:0] d, input logic [2:0] k, input logic left,
                        input logic [7:0] exp, input string nm);
        r1_valid = 1'b1; r1_data = d; r1_amt = k; r1_dir = left;
        tick();
        chk(nm, {24'b0, out_data}, {24'b0, exp});
        chk({nm, "_id"}, {31'b0, out_id}, 32'd1);
        r1_valid = 1'b0;
    endtask

    initial begin
        bit h0, h1;
        rst_n = 1'b0; out_ready = 1'b1;
        r0_valid = 0; r0_data = 0; r0_amt = 0; r0_dir = 0;
        r1_valid = 0; r1_data = 0; r1_amt = 0; r1_dir = 0;
        tick();
        do_reset();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", {24'b0, out_data}, 32'h00);

        // single requester, both directions
        r0_valid = 1; r0_data = 8'h81; r0_amt = 3'd1; r0_dir = 0;
        tick();
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_right", {24'b0, out_data}, 32'hC0);
        chk("t1_id", {31'b0, out_id}, 32'd0);
        chk("t1_cnt0", {16'b0, cnt0}, 32'd1);
        r0_dir = 1;
        tick();
        chk("t1_left", {24'b0, out_data}, 32'h03);
        r0_valid = 0;

        job1(8'hA5, 3'd4, 1'b0, 8'h5A, "t2_r4");
        job1(8'hA5, 3'd4, 1'b1, 8'h5A, "t2_l4");
        job1(8'h01, 3'd7, 1'b1, 8'h80, "t2_l7");
        job1(8'h01, 3'd7, 1'b0, 8'h02, "t2_r7");
        job1(8'hA5, 3'd0, 1'b0, 8'hA5, "t2_k0");

        // ties alternate starting from requester 0
        do_reset();
        r0_valid = 1; r1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            r0_data = 8'($urandom); r1_data = 8'($urandom);
            tick();
            chk("t3_id", {31'b0, out_id}, i % 2);
            chk("t3_valid", {31'b0, out_valid}, 32'd1);
        end
        r0_valid = 0; r1_valid = 0;
        chk("t3_cnt0", {16'b0, cnt0}, 32'd5);
        chk("t3_cnt1", {16'b0, cnt1}, 32'd5);
        chk("t3_s_cnt0", {30'b0, s_cnt0}, 32'd3);

        // back-pressure: r0 loads into the empty stage, then everything stalls
        do_reset();
        r0_valid = 1; r0_data = 8'h81; r0_amt = 3'd1; r0_dir = 0;
        r1_valid = 1; r1_data = 8'h0F; r1_amt = 3'd2; r1_dir = 1;
        out_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_data", {24'b0, out_data}, 32'hC0);
            chk("t4_hold_id", {31'b0, out_id}, 32'd0);
            chk("t4_no_rdy", {30'b0, r1_ready, r0_ready}, 32'd0);
        end
        out_ready = 1;
        #1;
        chk("t4_rdy1", {31'b0, r1_ready}, 32'd1);
        tick();
        chk("t4_swap_data", {24'b0, out_data}, 32'h3C);
        chk("t4_swap_id", {31'b0, out_id}, 32'd1);
        r0_valid = 0; r1_valid = 0;

        // reset while a result is held
        r0_valid = 1; out_ready = 0;
        tick();
        r0_valid = 0;
        tick();
        rst_n = 0;
        #1;
        chk("t5_rdy_in_rst", {31'b0, r0_ready}, 32'd0);
        tick();
        rst_n = 1;
        chk("t5_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_cnt", {cnt1, cnt0}, 32'd0);
        r0_valid = 1; r1_valid = 1; out_ready = 1;
        tick();
        chk("t5_first_tie", {31'b0, out_id}, 32'd0);
        r0_valid = 0; r1_valid = 0;

        // saturation on the narrow counter
        do_reset();
        r0_valid = 1; r0_data = 8'h81; r0_amt = 3'd1; r0_dir = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_s_data", {24'b0, s_out_data}, 32'hC0);
        end
        r0_valid = 0;
        chk("t6_s_cnt0", {30'b0, s_cnt0}, 32'd3);
        chk("t6_cnt0", {16'b0, cnt0}, 32'd5);
        tick();
        chk("t6_s_cnt0_hold", {30'b0, s_cnt0}, 32'd3);

        // random traffic; a stalled valid requester holds its job
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            h0 = r0_valid && !r0_ready;
            h1 = r1_valid && !r1_ready;
            tick();
            rst_n     = ($urandom_range(0, 199) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!h0) begin
                r0_valid = 1'($urandom); r0_data = 8'($urandom);
                r0_amt = 3'($urandom); r0_dir = 1'($urandom);
            end
            if (!h1) begin
                r1_valid = 1'($urandom); r1_data = 8'($urandom);
                r1_amt = 3'($urandom); r1_dir = 1'($urandom);
            end
        end
        rst_n = 1; r0_valid = 0; r1_valid = 0; out_ready = 1;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
